pid_multi_core: RTL and testbench

- Time-multiplexed, parametrised successor to the single-channel PID controller.
- Runs NUM_CH independent 2nd-order IIR PID loops on one shared registered multiply-accumulate (MAC) datapath, one channel after another.
- Per loop: y[k] = b0*e[k] + b1*e[k-1] + b2*e[k-2] - a1*y[k-1] - a0*y[k-2].
- Adds runtime output limits, anti-windup, per-channel hold, and a start/busy/done handshake with overrun flag. Sits between ADC sampling and the PWM stage of the fan controller.

---
 rtl/pid_pkg.sv | 28 ++
 rtl/pid_multi_core_mac.sv | 34 +++
 rtl/pid_multi_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_pid_multi_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the time-multiplexed PID controller: FSM encoding,
// MAC stage count and width helpers used to size the datapath.
package pid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WB,
        ST_DONE
    } pid_state_t;

    localparam int PID_STAGES = 5;
    localparam int STAGE_W    = 3;

    function automatic int mac_width(input int reg_bw, input int adc_bw);
        return 2 * (reg_bw + adc_bw + 1);
    endfunction

    // y history: output width plus fractional bits plus one guard bit
    function automatic int yh_width(input int adc_bw, input int frac_bw);
        return adc_bw + 1 + frac_bw + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pid_multi_core_mac.sv
// Registered signed multiply-accumulate shared by all PID channels.
// load=1 replaces the accumulator with the product, otherwise the product is added.
module pid_mac #(
    parameter int COEF_W = 33,
    parameter int OPND_W = 40,
    parameter int MAC_W  = 82
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [OPND_W-1:0] opnd,
    output logic signed [MAC_W-1:0]  acc
);

    logic signed [MAC_W-1:0] coef_ext;
    logic signed [MAC_W-1:0] opnd_ext;
    logic signed [MAC_W-1:0] prod;

    // The true product fits in MAC_W, so multiplying the extended operands is exact
    assign coef_ext = {{(MAC_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign opnd_ext = {{(MAC_W-OPND_W){opnd[OPND_W-1]}}, opnd};
    assign prod     = coef_ext * opnd_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? prod : acc + prod;
        end
    end

endmodule

// File: rtl/pid_multi_core.sv
// NUM_CH independent 2nd-order IIR PID loops sharing one MAC, swept channel by
// channel on start_i, with output clamp, anti-windup and per-channel hold.
module pid_multi_core
    import pid_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADC_BW  = 8,
    parameter int REG_BW  = 32,
    parameter int FRAC_BW = 30,
    parameter int MAC_W   = mac_width(REG_BW, ADC_BW)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [NUM_CH*ADC_BW-1:0]     adc_i,
    input  logic [NUM_CH*ADC_BW-1:0]     set_i,
    input  logic [NUM_CH-1:0]            hold_i,
    input  logic                         aw_en_i,
    input  logic signed [REG_BW-1:0]     b0_i,
    input  logic signed [REG_BW-1:0]     b1_i,
    input  logic signed [REG_BW-1:0]     b2_i,
    input  logic signed [REG_BW-1:0]     a1_i,
    input  logic signed [REG_BW-1:0]     a0_i,
    input  logic signed [ADC_BW:0]       out_min_i,
    input  logic signed [ADC_BW:0]       out_max_i,
    output logic [NUM_CH*(ADC_BW+1)-1:0] out_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         overrun_o,
    output logic [NUM_CH-1:0]            sat_o
);

    localparam int OW     = ADC_BW + 1;
    localparam int YH_W   = yh_width(ADC_BW, FRAC_BW);
    localparam int CH_W   = idx_width(NUM_CH);
    localparam int COEF_W = REG_BW + 1;

    localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(PID_STAGES - 1);
    localparam logic signed [YH_W-1:0] Y_MAX_H   = {1'b0, {(YH_W-1){1'b1}}};
    localparam logic signed [YH_W-1:0] Y_MIN_H   = {1'b1, {(YH_W-2){1'b0}}, 1'b1};
    localparam logic signed [MAC_W-1:0] Y_HI     = {{(MAC_W-YH_W){1'b0}}, Y_MAX_H};
    localparam logic signed [MAC_W-1:0] Y_LO     = {{(MAC_W-YH_W){1'b1}}, Y_MIN_H};

    pid_state_t state;
    logic [STAGE_W-1:0] stage;
    logic [CH_W-1:0]    ch;

    logic [NUM_CH*ADC_BW-1:0] adc_l;
    logic [NUM_CH*ADC_BW-1:0] set_l;
    logic [NUM_CH-1:0]        hold_l;
    logic signed [REG_BW-1:0] b0_l, b1_l, b2_l, a1_l, a0_l;
    logic signed [OW-1:0]     min_l, max_l;

    logic signed [OW-1:0]   e1_h [NUM_CH];
    logic signed [OW-1:0]   e2_h [NUM_CH];
    logic signed [YH_W-1:0] y1_h [NUM_CH];
    logic signed [YH_W-1:0] y2_h [NUM_CH];

    logic signed [OW-1:0]     e0;
    logic signed [COEF_W-1:0] coef;
    logic signed [YH_W-1:0]   opnd;
    logic signed [MAC_W-1:0]  acc;
    logic signed [MAC_W-1:0]  res;
    logic signed [MAC_W-1:0]  y_raw;
    logic signed [MAC_W-1:0]  min_ext, max_ext;
    logic signed [OW-1:0]     clamped;
    logic                     clamp;
    logic signed [YH_W-1:0]   y_sat;
    logic signed [YH_W-1:0]   y_next;

    logic            first_found, next_found;
    logic [CH_W-1:0] first_idx, next_idx;

    // Lowest non-held channel at or above 'from'; MSB flags whether one exists
    function automatic logic [CH_W:0] find_active(input logic [NUM_CH-1:0] mask, input int from);
        logic [CH_W:0] found;
        found = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i >= from && !mask[i]) begin
                found = {1'b1, CH_W'(i)};
            end
        end
        return found;
    endfunction

    assign {first_found, first_idx} = find_active(hold_i, 0);
    assign {next_found, next_idx}   = find_active(hold_l, int'(ch) + 1);

    assign e0 = {1'b0, set_l[int'(ch)*ADC_BW +: ADC_BW]} - {1'b0, adc_l[int'(ch)*ADC_BW +: ADC_BW]};

    // Feedback terms enter the MAC with negated denominator coefficients
    always_comb begin
        coef = '0;
        opnd = '0;
        case (stage)
            3'd0: begin
                coef = {b0_l[REG_BW-1], b0_l};
                opnd = {e0[OW-1], e0, {FRAC_BW{1'b0}}};
            end
            3'd1: begin
                coef = {b1_l[REG_BW-1], b1_l};
                opnd = {e1_h[ch][OW-1], e1_h[ch], {FRAC_BW{1'b0}}};
            end
            3'd2: begin
                coef = {b2_l[REG_BW-1], b2_l};
                opnd = {e2_h[ch][OW-1], e2_h[ch], {FRAC_BW{1'b0}}};
            end
            3'd3: begin
                coef = -{a1_l[REG_BW-1], a1_l};
                opnd = y1_h[ch];
            end
            3'd4: begin
                coef = -{a0_l[REG_BW-1], a0_l};
                opnd = y2_h[ch];
            end
            default: begin
                coef = '0;
                opnd = '0;
            end
        endcase
    end

    pid_mac #(
        .COEF_W (COEF_W),
        .OPND_W (YH_W),
        .MAC_W  (MAC_W)
    ) u_mac (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (state == ST_MAC),
        .load  (stage == '0),
        .coef  (coef),
        .opnd  (opnd),
        .acc   (acc)
    );

    assign min_ext = {{(MAC_W-OW){min_l[OW-1]}}, min_l};
    assign max_ext = {{(MAC_W-OW){max_l[OW-1]}}, max_l};

    always_comb begin
        res     = acc >>> (2 * FRAC_BW);
        y_raw   = acc >>> FRAC_BW;
        clamped = res[OW-1:0];
        clamp   = 1'b0;
        if (res > max_ext) begin
            clamped = max_l;
            clamp   = 1'b1;
        end else if (res < min_ext) begin
            clamped = min_l;
            clamp   = 1'b1;
        end
        y_sat = y_raw[YH_W-1:0];
        if (y_raw > Y_HI) begin
            y_sat = Y_MAX_H;
        end else if (y_raw < Y_LO) begin
            y_sat = Y_MIN_H;
        end
        y_next = (aw_en_i && clamp) ? {clamped[OW-1], clamped, {FRAC_BW{1'b0}}} : y_sat;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            stage     <= '0;
            ch        <= '0;
            adc_l     <= '0;
            set_l     <= '0;
            hold_l    <= '0;
            b0_l      <= '0;
            b1_l      <= '0;
            b2_l      <= '0;
            a1_l      <= '0;
            a0_l      <= '0;
            min_l     <= '0;
            max_l     <= '0;
            out_o     <= '0;
            sat_o     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                e1_h[i] <= '0;
                e2_h[i] <= '0;
                y1_h[i] <= '0;
                y2_h[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            if (start_i && state != ST_IDLE) begin
                overrun_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        adc_l  <= adc_i;
                        set_l  <= set_i;
                        hold_l <= hold_i;
                        b0_l   <= b0_i;
                        b1_l   <= b1_i;
                        b2_l   <= b2_i;
                        a1_l   <= a1_i;
                        a0_l   <= a0_i;
                        min_l  <= out_min_i;
                        max_l  <= out_max_i;
                        stage  <= '0;
                        if (first_found) begin
                            ch     <= first_idx;
                            state  <= ST_MAC;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (stage == LAST_STAGE) begin
                        state <= ST_WB;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                ST_WB: begin
                    out_o[int'(ch)*OW +: OW] <= clamped;
                    sat_o[ch] <= clamp;
                    e2_h[ch]  <= e1_h[ch];
                    e1_h[ch]  <= e0;
                    y2_h[ch]  <= y1_h[ch];
                    y1_h[ch]  <= y_next;
                    stage     <= '0;
                    if (next_found) begin
                        ch    <= next_idx;
                        state <= ST_MAC;
                    end else begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_multi_core.sv
// Scoreboard bench for pid_multi_core: a formula-level model predicts each sweep,
// and a monitor compares outputs whenever done_o pulses.
module tb_pid_multi_core;

    localparam int NUM_CH  = 4;
    localparam int ADC_BW  = 8;
    localparam int REG_BW  = 32;
    localparam int FRAC_BW = 30;
    localparam int OW      = ADC_BW + 1;
    localparam longint ONE = 64'sd1 <<< FRAC_BW;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic [NUM_CH*ADC_BW-1:0] adc_i = '0;
    logic [NUM_CH*ADC_BW-1:0] set_i = '0;
    logic [NUM_CH-1:0] hold_i = '0;
    logic aw_en_i = 1'b0;
    logic signed [REG_BW-1:0] b0_i = '0, b1_i = '0, b2_i = '0, a1_i = '0, a0_i = '0;
    logic signed [ADC_BW:0] out_min_i = '0, out_max_i = '0;
    logic [NUM_CH*OW-1:0] out_o;
    logic busy_o, done_o, overrun_o;
    logic [NUM_CH-1:0] sat_o;

    pid_multi_core #(
        .NUM_CH  (NUM_CH),
        .ADC_BW  (ADC_BW),
        .REG_BW  (REG_BW),
        .FRAC_BW (FRAC_BW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .adc_i     (adc_i),
        .set_i     (set_i),
        .hold_i    (hold_i),
        .aw_en_i   (aw_en_i),
        .b0_i      (b0_i),
        .b1_i      (b1_i),
        .b2_i      (b2_i),
        .a1_i      (a1_i),
        .a0_i      (a0_i),
        .out_min_i (out_min_i),
        .out_max_i (out_max_i),
        .out_o     (out_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o),
        .sat_o     (sat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH*OW-1:0] out;
        logic [NUM_CH-1:0]    sat;
        int                   latency;
        int                   start_cyc;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Bench-side stimulus values
    int adc_v[NUM_CH];
    int set_v[NUM_CH];
    logic [NUM_CH-1:0] hold_v;
    longint b0_v, b1_v, b2_v, a1_v, a0_v;
    int min_v, max_v;

    // Reference model state: integer errors, y in FRAC_BW fixed point
    int m_e1[NUM_CH], m_e2[NUM_CH];
    logic signed [127:0] m_y1[NUM_CH], m_y2[NUM_CH];
    int m_out[NUM_CH];
    logic [NUM_CH-1:0] m_sat;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint outCh(input logic [NUM_CH*OW-1:0] v, input int c);
        logic signed [OW-1:0] s;
        s = v[c*OW +: OW];
        return longint'(s);
    endfunction

    always @(negedge clk) begin
        if (done_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got done_o=1, expected no sweep outstanding");
            end else begin
                mon_e = sb_q.pop_front();
                for (int c = 0; c < NUM_CH; c++)
                    checkOutput($sformatf("out_ch%0d", c), outCh(out_o, c), outCh(mon_e.out, c));
                checkOutput("sat_mask", longint'(sat_o), longint'(mon_e.sat));
                checkOutput("done_latency", longint'(cyc - mon_e.start_cyc), longint'(mon_e.latency));
                checkOutput("busy_at_done", longint'(busy_o), 0);
            end
        end
    end

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = '0; m_y2[c] = '0; m_out[c] = 0;
        end
        m_sat = '0;
    endtask

    task automatic modelSweep(output sb_t ent);
        logic signed [127:0] acc, e0w, e1w, e2w, ylim, ynew;
        logic signed [127:0] cb0, cb1, cb2, ca1, ca0;
        longint r;
        int e0, active;
        logic [OW-1:0] o9;
        active = 0;
        ylim = (128'sd1 <<< (ADC_BW + 1 + FRAC_BW)) - 1;
        cb0 = b0_v; cb1 = b1_v; cb2 = b2_v; ca1 = a1_v; ca0 = a0_v;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!hold_v[c]) begin
                active++;
                e0  = set_v[c] - adc_v[c];
                e0w = e0;        e0w = e0w <<< FRAC_BW;
                e1w = m_e1[c];   e1w = e1w <<< FRAC_BW;
                e2w = m_e2[c];   e2w = e2w <<< FRAC_BW;
                acc = cb0 * e0w + cb1 * e1w + cb2 * e2w - ca1 * m_y1[c] - ca0 * m_y2[c];
                r = longint'(acc >>> (2 * FRAC_BW));
                if (r > max_v) begin m_out[c] = max_v; m_sat[c] = 1'b1; end
                else if (r < min_v) begin m_out[c] = min_v; m_sat[c] = 1'b1; end
                else begin m_out[c] = int'(r); m_sat[c] = 1'b0; end
                if (aw_en_i && m_sat[c]) begin
                    ynew = m_out[c];
                    ynew = ynew <<< FRAC_BW;
                end else begin
                    ynew = acc >>> FRAC_BW;
                    if (ynew > ylim) ynew = ylim;
                    else if (ynew < -ylim) ynew = -ylim;
                end
                m_e2[c] = m_e1[c]; m_e1[c] = e0;
                m_y2[c] = m_y1[c]; m_y1[c] = ynew;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            o9 = OW'(m_out[c]);
            ent.out[c*OW +: OW] = o9;
        end
        ent.sat = m_sat;
        ent.latency = 6 * active + 1;
        ent.start_cyc = 0;
    endtask

    task automatic driveInputs();
        for (int c = 0; c < NUM_CH; c++) begin
            adc_i[c*ADC_BW +: ADC_BW] = ADC_BW'(adc_v[c]);
            set_i[c*ADC_BW +: ADC_BW] = ADC_BW'(set_v[c]);
        end
        hold_i = hold_v;
        b0_i = REG_BW'(b0_v); b1_i = REG_BW'(b1_v); b2_i = REG_BW'(b2_v);
        a1_i = REG_BW'(a1_v); a0_i = REG_BW'(a0_v);
        out_min_i = OW'(min_v); out_max_i = OW'(max_v);
    endtask

    // Called at a negedge with the DUT idle; pulses start_i for one cycle
    task automatic applyStimulus(input bit scramble);
        sb_t ent;
        driveInputs();
        modelSweep(ent);
        ent.start_cyc = cyc;
        sb_q.push_back(ent);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (scramble) begin
            adc_i = $urandom; set_i = $urandom; hold_i = NUM_CH'($urandom);
            b0_i = $urandom; b1_i = $urandom; b2_i = $urandom; a1_i = $urandom; a0_i = $urandom;
            out_min_i = OW'($urandom); out_max_i = OW'($urandom);
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL done_timeout: got no done_o within 400 cycles, expected a sweep completion");
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        modelReset();
    endtask

    task automatic setPureP();
        b0_v = ONE; b1_v = 0; b2_v = 0; a1_v = 0; a0_v = 0;
        min_v = -256; max_v = 255;
    endtask

    task automatic setErrors(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int c = 0; c < NUM_CH; c++) begin
            if (e[c] >= 0) begin set_v[c] = e[c]; adc_v[c] = 0; end
            else begin set_v[c] = 0; adc_v[c] = -e[c]; end
        end
    endtask

    int aw_outs[4] = '{30, 50, 50, 40};

    initial begin
        $display("[TB] start");
        modelReset();
        setPureP();
        setErrors(0, 0, 0, 0);
        hold_v = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("reset_out", longint'(out_o), 0);
        checkOutput("reset_busy", longint'(busy_o), 0);
        checkOutput("reset_done", longint'(done_o), 0);
        checkOutput("reset_overrun", longint'(overrun_o), 0);
        checkOutput("reset_sat", longint'(sat_o), 0);

        // Pure P on channel 0 only
        setPureP();
        set_v[0] = 100; adc_v[0] = 60;
        hold_v = 4'b1110;
        applyStimulus(1'b0);
        checkOutput("busy_after_start", longint'(busy_o), 1);
        waitDone();
        checkOutput("pure_p_out", outCh(out_o, 0), 40);

        // Integrator with clamp, anti-windup on
        doReset();
        b0_v = ONE; a1_v = -ONE; b1_v = 0; b2_v = 0; a0_v = 0;
        min_v = -50; max_v = 50;
        aw_en_i = 1'b1;
        hold_v = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            adc_v[0] = 100;
            set_v[0] = (k < 3) ? 130 : 90;
            applyStimulus(1'b0);
            waitDone();
            checkOutput($sformatf("aw_on_sweep%0d", k), outCh(out_o, 0), aw_outs[k]);
        end

        // Same integrator without anti-windup: slow recovery
        doReset();
        aw_en_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            adc_v[0] = 100;
            set_v[0] = (k < 3) ? 130 : 90;
            applyStimulus(1'b0);
            waitDone();
        end
        checkOutput("aw_off_final", outCh(out_o, 0), 40);

        // Four channels, pure P
        doReset();
        setPureP();
        hold_v = '0;
        setErrors(10, -20, 0, 127);
        applyStimulus(1'b1);
        waitDone();
        checkOutput("multi_ch3", outCh(out_o, 3), 127);

        // Hold mask: channels 0 and 2 frozen
        setErrors(-5, 33, 44, -99);
        hold_v = 4'b0101;
        applyStimulus(1'b1);
        waitDone();

        // All channels held
        hold_v = 4'b1111;
        applyStimulus(1'b0);
        waitDone();

        // Overrun: second start three cycles into a sweep
        hold_v = '0;
        setErrors(1, 2, 3, 4);
        applyStimulus(1'b0);
        @(negedge clk); @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        waitDone();
        checkOutput("overrun_set", longint'(overrun_o), 1);

        // Reset mid-sweep aborts without writeback
        setErrors(7, 8, 9, 10);
        applyStimulus(1'b0);
        repeat (8) @(negedge clk);
        sb_q.delete();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        modelReset();
        checkOutput("abort_out", longint'(out_o), 0);
        checkOutput("abort_busy", longint'(busy_o), 0);
        checkOutput("abort_overrun", longint'(overrun_o), 0);
        checkOutput("abort_sat", longint'(sat_o), 0);

        // start_i coincident with reset is ignored
        rst_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        checkOutput("reset_wins_busy", longint'(busy_o), 0);

        // Randomized sweeps
        for (int k = 0; k < 30; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                adc_v[c] = int'($urandom_range(255));
                set_v[c] = int'($urandom_range(255));
            end
            hold_v = NUM_CH'($urandom);
            if ($urandom_range(3) == 0) begin
                b0_v = longint'($signed(32'($urandom))); b1_v = longint'($signed(32'($urandom)));
                b2_v = longint'($signed(32'($urandom))); a1_v = longint'($signed(32'($urandom)));
                a0_v = longint'($signed(32'($urandom)));
            end else begin
                b0_v = longint'($urandom_range(2 * ONE)) - ONE;
                b1_v = longint'($urandom_range(ONE)) - ONE / 2;
                b2_v = longint'($urandom_range(ONE / 2)) - ONE / 4;
                a1_v = longint'($urandom_range(ONE)) - ONE;
                a0_v = longint'($urandom_range(ONE / 2)) - ONE / 4;
            end
            min_v = int'($urandom_range(511)) - 256;
            max_v = min_v + int'($urandom_range(255 - min_v));
            aw_en_i = 1'($urandom);
            applyStimulus(1'b1);
            waitDone();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
